// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage - store formatting, load alignment, and
//            pipeline stall until the data cache responds.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid,
  input  logic        exmem_mem_read,
  input  logic        exmem_mem_write,
  input  logic [2:0]  exmem_funct3,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_rs2_out,
  input  logic        flush,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        mem_timeout
);

  localparam logic [31:0] c_timeout = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_read;
  logic        r_write;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [3:0]  r_mbe;
  logic [31:0] r_rdata;
  logic        r_timeout;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_flushed;
  logic [31:0] r_wait_cnt;

  logic [1:0]  w_off;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_mis_raw;
  logic        w_mem_slot;
  logic        w_op;
  logic        w_stall;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  // Access size decode; any funct3 that is not a legal byte/half code is a word.
  always_comb begin
    w_off      = exmem_alu_out[1:0];
    w_is_byte  = (exmem_funct3 == 3'd0) | (exmem_mem_read & (exmem_funct3 == 3'd4));
    w_is_half  = (exmem_funct3 == 3'd1) | (exmem_mem_read & (exmem_funct3 == 3'd5));
    w_is_word  = ~w_is_byte & ~w_is_half;
    w_mis_raw  = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));
    w_mem_slot = exmem_valid & (exmem_mem_read | exmem_mem_write) & ~flush;
    w_op       = w_mem_slot & ~w_mis_raw;
  end

  always_comb begin
    w_mbe   = 4'hF;
    w_wdata = '0;
    if (exmem_mem_write) begin
      if (w_is_byte) begin
        w_mbe   = 4'b0001 << w_off;
        w_wdata = {24'b0, exmem_rs2_out[7:0]} << {w_off, 3'b000};
      end else if (w_is_half) begin
        w_mbe   = 4'b0011 << w_off;
        w_wdata = {16'b0, exmem_rs2_out[15:0]} << {w_off, 3'b000};
      end else begin
        w_wdata = exmem_rs2_out;
      end
    end
  end

  // Load formatting uses the funct3/offset latched at issue time.
  always_comb begin
    w_shifted = dmem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd4:    w_load_data = {24'b0, w_shifted[7:0]};
      3'd5:    w_load_data = {16'b0, w_shifted[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op) begin
          w_state_nxt = S_BUSY;
          w_stall     = 1'b1;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (dmem_resp) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
      r_mbe     <= '0;
      r_rdata   <= '0;
      r_funct3  <= '0;
      r_off     <= '0;
      r_flushed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            r_read    <= exmem_mem_read;
            r_write   <= exmem_mem_write;
            r_address <= {exmem_alu_out[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_mbe     <= w_mbe;
            r_funct3  <= exmem_funct3;
            r_off     <= w_off;
            r_flushed <= 1'b0;
          end
        end
        S_BUSY: begin
          // The cache cannot abort, so a flush only poisons the returned data.
          if (flush) r_flushed <= 1'b1;
          if (dmem_resp) begin
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_mbe     <= '0;
            r_rdata   <= (r_flushed | flush | r_write) ? 32'd0 : w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state != S_BUSY || dmem_resp)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != '1)
        r_wait_cnt <= r_wait_cnt + 32'd1;
      if (r_state == S_BUSY && c_timeout != 32'd0 && r_wait_cnt >= c_timeout - 32'd1)
        r_timeout <= 1'b1;
    end
  end

  assign dmem_read      = r_read;
  assign dmem_write     = r_write;
  assign dmem_address   = r_address;
  assign dmem_wdata     = r_wdata;
  assign dmem_mbe       = r_mbe;
  assign mem_rdata      = r_rdata;
  assign mem_timeout    = r_timeout;
  assign mem_stall      = w_stall;
  assign mem_misaligned = w_mem_slot & w_mis_raw & (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage: directed table, random ops
//            against a size/offset reference model, flush and watchdog cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid, exmem_mem_read, exmem_mem_write;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_out, exmem_rs2_out;
  logic        flush;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_rdata;
  logic        mem_stall, mem_misaligned, mem_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .exmem_valid(exmem_valid), .exmem_mem_read(exmem_mem_read),
    .exmem_mem_write(exmem_mem_write), .exmem_funct3(exmem_funct3),
    .exmem_alu_out(exmem_alu_out), .exmem_rs2_out(exmem_rs2_out),
    .flush(flush),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .mem_misaligned(mem_misaligned), .mem_timeout(mem_timeout)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          dly;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_mbe;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: access width in bytes, then plain shift/mask arithmetic.
  function automatic vec_t model(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rdata, input int dly);
    vec_t v;
    int sz, off;
    logic [31:0] mask, val;
    sz = 4;
    if (f3 == 3'd0 || (rd && f3 == 3'd4)) sz = 1;
    if (f3 == 3'd1 || (rd && f3 == 3'd5)) sz = 2;
    off = int'(addr % 4);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v.rd = rd; v.wr = !rd; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.dly = dly;
    v.mis    = (off % sz) != 0;
    v.e_addr = addr - 32'(off);
    v.e_mbe  = rd ? 4'hF : 4'(((1 << sz) - 1) << off);
    v.e_wdata = (rs2 & mask) << (8 * off);
    val = (rdata >> (8 * off)) & mask;
    if (sz < 4 && !f3[2] && val[8 * sz - 1]) val = val | ~mask;
    v.e_rdata = val;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int flush_at);
    @(posedge clk); #1;
    exmem_valid = 1'b1; exmem_mem_read = v.rd; exmem_mem_write = v.wr;
    exmem_funct3 = v.f3; exmem_alu_out = v.addr; exmem_rs2_out = v.rs2; flush = 1'b0;
    @(negedge clk);
    chk("misaligned", 32'(mem_misaligned), 32'(v.mis));
    if (v.mis) begin
      chk("stall_misaligned", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      chk("misaligned_no_request", 32'(dmem_read | dmem_write), 32'd0);
      exmem_valid = 1'b0;
      return;
    end
    chk("stall_issue", 32'(mem_stall), 32'd1);
    for (int k = 0; k < v.dly; k++) begin
      @(posedge clk); #1;
      flush      = (k == flush_at);
      dmem_resp  = (k == v.dly - 1);
      dmem_rdata = dmem_resp ? v.rdata : $urandom;
      @(negedge clk);
      chk("busy_read", 32'(dmem_read), 32'(v.rd));
      chk("busy_write", 32'(dmem_write), 32'(v.wr));
      chk("busy_address", dmem_address, v.e_addr);
      chk("busy_mbe", 32'(dmem_mbe), 32'(v.e_mbe));
      if (v.wr) chk("busy_wdata", dmem_wdata, v.e_wdata);
      chk("busy_stall", 32'(mem_stall), 32'd1);
    end
    @(posedge clk); #1;
    dmem_resp = 1'b0; flush = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", 32'(mem_stall), 32'd0);
    chk("done_strobes", 32'(dmem_read | dmem_write), 32'd0);
    if (v.rd) chk("load_data", mem_rdata, (flush_at >= 0) ? 32'd0 : v.e_rdata);
    chk("done_timeout", 32'(mem_timeout), 32'd0);
    @(posedge clk); #1;
    exmem_valid = 1'b0;
    @(negedge clk);
    chk("no_reissue", 32'(dmem_read | dmem_write | mem_stall), 32'd0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    rst = 1'b1; exmem_valid = 1'b0; exmem_mem_read = 1'b0; exmem_mem_write = 1'b0;
    exmem_funct3 = 3'd0; exmem_alu_out = '0; exmem_rs2_out = '0; flush = 1'b0;
    dmem_rdata = '0; dmem_resp = 1'b0;

    //          rd    wr    f3    addr          rs2           rdata         dly mis   e_addr        e_mbe    e_wdata       e_rdata
    tbl[0]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0100, 4'hF,    32'h0,        32'hDEAD_BEEF};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 1'b0, 32'h0000_0100, 4'hF,    32'h0,        32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_0000, 2, 1'b0, 32'h0000_0100, 4'hF,    32'h0,        32'h0000_0080};
    tbl[3]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0,        32'h80FF_0000, 1, 1'b0, 32'h0000_0100, 4'hF,    32'h0,        32'h0000_80FF};
    tbl[4]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0206, 32'h1234_ABCD, 32'h0,        2, 1'b0, 32'h0000_0204, 4'b1100, 32'hABCD_0000, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        1, 1'b1, 32'h0,        4'h0,    32'h0,        32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0101, 32'hAABB_CC55, 32'h0,        1, 1'b0, 32'h0000_0100, 4'b0010, 32'h0000_5500, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 3, 1'b0, 32'h0000_0200, 4'hF,    32'h0,        32'hFFFF_8001};
    tbl[8]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0203, 32'h1111_2222, 32'h0,        1, 1'b1, 32'h0,        4'h0,    32'h0,        32'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0104, 32'h0,        32'h1234_5678, 2, 1'b0, 32'h0000_0104, 4'hF,    32'h0,        32'h1234_5678};
    tbl[10] = '{1'b0, 1'b1, 3'd2, 32'h0000_0308, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 32'h0000_0308, 4'hF,    32'hCAFE_F00D, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_read", 32'(dmem_read), 32'd0);
    chk("reset_write", 32'(dmem_write), 32'd0);
    chk("reset_address", dmem_address, 32'd0);
    chk("reset_mbe", 32'(dmem_mbe), 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    chk("reset_stall_timeout", 32'({mem_stall, mem_timeout, mem_misaligned}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(tbl[i], -1);

    // Non-memory slot: no stall, no request.
    @(posedge clk); #1;
    exmem_valid = 1'b1; exmem_mem_read = 1'b0; exmem_mem_write = 1'b0; exmem_alu_out = 32'h101;
    @(negedge clk);
    chk("nonmem_stall", 32'(mem_stall | mem_misaligned), 32'd0);
    @(posedge clk); #1;
    chk("nonmem_no_request", 32'(dmem_read | dmem_write), 32'd0);
    exmem_valid = 1'b0;

    // Flush in IDLE suppresses the op entirely.
    @(posedge clk); #1;
    exmem_valid = 1'b1; exmem_mem_read = 1'b1; exmem_funct3 = 3'd2; exmem_alu_out = 32'h300; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    chk("idle_flush_no_request", 32'(dmem_read), 32'd0);
    exmem_valid = 1'b0; flush = 1'b0;

    // Flush while BUSY: request held to resp, data discarded.
    run_op(model(1'b1, 3'd2, 32'h0000_0300, 32'h0, 32'h1111_2222, 3), 1);
    run_op(model(1'b1, 3'd0, 32'h0000_0301, 32'h0, 32'h0000_9900, 2), 1);

    for (int i = 0; i < 40; i++) begin
      rv = model(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, $urandom,
                 int'($urandom_range(1, 3)));
      run_op(rv, -1);
    end

    // Watchdog: withhold resp, then reset mid-BUSY.
    @(posedge clk); #1;
    exmem_valid = 1'b1; exmem_mem_read = 1'b1; exmem_mem_write = 1'b0;
    exmem_funct3 = 3'd2; exmem_alu_out = 32'h400;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_timeout", 32'(mem_timeout), (k >= 4) ? 32'd1 : 32'd0);
      chk("wd_read_held", 32'(dmem_read & mem_stall), 32'd1);
    end
    @(posedge clk); #1;
    exmem_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_busy_strobes", 32'({dmem_read, dmem_write, mem_stall, mem_timeout}), 32'd0);
    chk("rst_mid_busy_address", dmem_address, 32'd0);
    chk("rst_mid_busy_mbe", 32'(dmem_mbe), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", 32'({dmem_read, mem_stall, mem_timeout}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
